// File: rtl/inst_queue_mw.sv
// Multi-wide in-order instruction queue between fetch and decode.
// Accepts up to WR_WIDTH entries and presents up to RD_WIDTH oldest entries per cycle.
module inst_queue_mw #(
    parameter int ENTRY_WIDTH = 102,
    parameter int DEPTH       = 16,
    parameter int WR_WIDTH    = 2,
    parameter int RD_WIDTH    = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [WR_WIDTH-1:0]             enq_valid,
    input  logic [WR_WIDTH*ENTRY_WIDTH-1:0] enq_data,
    output logic                            enq_ready,
    output logic [RD_WIDTH-1:0]             deq_valid,
    output logic [RD_WIDTH*ENTRY_WIDTH-1:0] deq_data,
    input  logic [RD_WIDTH-1:0]             deq_ready,
    output logic [$clog2(DEPTH):0]          count,
    output logic                            full,
    output logic                            empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [ENTRY_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] n_enq;
    logic [PTR_W-1:0] n_deq;
    logic             enq_run;
    logic             deq_run;
    logic             do_enq;
    logic [IDX_W-1:0] rd_idx;

    // Only the leading run of valid slots is enqueued; later slots are ignored.
    always_comb begin
        n_enq   = '0;
        enq_run = 1'b1;
        for (int unsigned i = 0; i < WR_WIDTH; i++) begin
            enq_run = enq_run & enq_valid[i];
            if (enq_run) n_enq = n_enq + PTR_W'(1);
        end
    end

    // All-or-nothing space check on registered occupancy only.
    assign enq_ready = !flush && ((PTR_W'(DEPTH) - count) >= PTR_W'(WR_WIDTH));
    assign do_enq    = enq_ready && (n_enq != '0);

    always_comb begin
        deq_valid = '0;
        deq_data  = '0;
        rd_idx    = '0;
        for (int unsigned i = 0; i < RD_WIDTH; i++) begin
            deq_valid[i] = !flush && (count > PTR_W'(i));
            rd_idx       = rd_ptr[IDX_W-1:0] + IDX_W'(i);
            if (deq_valid[i]) deq_data[i*ENTRY_WIDTH +: ENTRY_WIDTH] = mem[rd_idx];
        end
    end

    always_comb begin
        n_deq   = '0;
        deq_run = 1'b1;
        for (int unsigned i = 0; i < RD_WIDTH; i++) begin
            deq_run = deq_run & deq_ready[i] & deq_valid[i];
            if (deq_run) n_deq = n_deq + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + n_enq;
            rd_ptr <= rd_ptr + n_deq;
            count  <= count + (do_enq ? n_enq : '0) - n_deq;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < WR_WIDTH; i++) begin
            if (do_enq && (PTR_W'(i) < n_enq))
                mem[wr_ptr[IDX_W-1:0] + IDX_W'(i)] <= enq_data[i*ENTRY_WIDTH +: ENTRY_WIDTH];
        end
    end

    assign full  = (count == PTR_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: tb/tb_inst_queue_mw.sv
// Scoreboard bench for inst_queue_mw: driver pushes expected entries, monitor checks every cycle.
module tb_inst_queue_mw;

    localparam int EW    = 102;
    localparam int DEPTH = 16;
    localparam int WW    = 2;
    localparam int RW    = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic [WW-1:0]     enq_valid;
    logic [WW*EW-1:0]  enq_data;
    logic              enq_ready;
    logic [RW-1:0]     deq_valid;
    logic [RW*EW-1:0]  deq_data;
    logic [RW-1:0]     deq_ready;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;

    inst_queue_mw #(
        .ENTRY_WIDTH(EW),
        .DEPTH(DEPTH),
        .WR_WIDTH(WW),
        .RD_WIDTH(RW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .enq_valid(enq_valid),
        .enq_data(enq_data),
        .enq_ready(enq_ready),
        .deq_valid(deq_valid),
        .deq_data(deq_data),
        .deq_ready(deq_ready),
        .count(count),
        .full(full),
        .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp_q mirrors queue contents after the last edge; pend_q holds entries accepted at the next edge.
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] pend_q[$];
    int unsigned   n_tests = 0;
    int unsigned   n_fail  = 0;
    int unsigned   next_pc = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lead(input logic [3:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [EW-1:0] mk(input logic [31:0] pc);
        logic [31:0] tgt;
        logic [5:0]  bits;
        logic [31:0] inst;
        tgt  = $urandom();
        bits = 6'($urandom());
        inst = $urandom();
        return {tgt, bits, pc, inst};
    endfunction

    // Called at posedge+1; drives one cycle of stimulus and returns at the next posedge+1.
    task automatic drive(input logic [WW-1:0] ev, input logic [RW-1:0] dr, input logic fl);
        logic [WW*EW-1:0] d;
        logic [EW-1:0]    e;
        int               n;
        bit               acc;
        enq_valid = ev;
        deq_ready = dr;
        flush     = fl;
        n   = lead(4'(ev));
        acc = !fl && rst_n && ((DEPTH - exp_q.size()) >= WW) && (n > 0);
        d   = '0;
        for (int i = 0; i < WW; i++) begin
            if (acc && i < n) begin
                e = mk(next_pc);
                next_pc += 4;
                pend_q.push_back(e);
            end else begin
                e = mk($urandom());
            end
            d[i*EW +: EW] = e;
        end
        enq_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int cycles, input logic [WW-1:0] ev, input logic [RW-1:0] dr);
        for (int k = 0; k < cycles; k++) drive(ev, dr, 1'b0);
    endtask

    // Commit accepted entries at the edge that writes them.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) pend_q.delete();
            while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
        end
    end

    // Monitor: compare every output against the model at each falling edge.
    initial begin
        int occ;
        int nd;
        bit vi;
        bit chain;
        logic [EW-1:0] want;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_count", 128'(count), 128'(0));
                check("rst_deq_valid", 128'(deq_valid), 128'(0));
                for (int i = 0; i < RW; i++) check("rst_deq_data", 128'(deq_data[i*EW +: EW]), 128'(0));
                check("rst_enq_ready", 128'(enq_ready), 128'(1));
                check("rst_empty", 128'(empty), 128'(1));
                check("rst_full", 128'(full), 128'(0));
                exp_q.delete();
                pend_q.delete();
            end else begin
                occ = exp_q.size();
                check("count", 128'(count), 128'(occ));
                check("full", 128'(full), 128'(occ == DEPTH));
                check("empty", 128'(empty), 128'(occ == 0));
                check("enq_ready", 128'(enq_ready), 128'(!flush && (DEPTH - occ) >= WW));
                nd    = 0;
                chain = 1'b1;
                for (int i = 0; i < RW; i++) begin
                    vi = !flush && (occ > i);
                    check("deq_valid", 128'(deq_valid[i]), 128'(vi));
                    if (vi) want = exp_q[i];
                    else    want = '0;
                    check("deq_data", 128'(deq_data[i*EW +: EW]), 128'(want));
                    chain = chain && vi && deq_ready[i];
                    if (chain) nd++;
                end
                if (flush) exp_q.delete();
                else repeat (nd) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        enq_valid = '0;
        deq_ready = '0;
        enq_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", 128'(count), 128'(0));
        check("reset_enq_ready", 128'(enq_ready), 128'(1));
        check("reset_empty", 128'(empty), 128'(1));
        rst_n = 1'b1;

        // Fill and drain
        run(8, 2'b11, 2'b00);
        check("fill_count", 128'(count), 128'(16));
        check("fill_full", 128'(full), 128'(1));
        check("fill_enq_ready", 128'(enq_ready), 128'(0));
        check("fill_head_pc", 128'(deq_data[63:32]), 128'(0));
        check("fill_slot1_pc", 128'(deq_data[EW+63:EW+32]), 128'(32'h4));
        run(8, 2'b00, 2'b11);
        check("drain_empty", 128'(empty), 128'(1));

        // Threshold and partial dequeue
        run(7, 2'b11, 2'b00);
        run(1, 2'b01, 2'b00);
        check("thr_count15", 128'(count), 128'(15));
        check("thr_enq_ready15", 128'(enq_ready), 128'(0));
        run(1, 2'b01, 2'b00);
        check("thr_no_write", 128'(count), 128'(15));
        run(1, 2'b00, 2'b01);
        check("thr_count14", 128'(count), 128'(14));
        check("thr_enq_ready14", 128'(enq_ready), 128'(1));
        run(1, 2'b00, 2'b10);
        check("thr_no_pop", 128'(count), 128'(14));
        run(7, 2'b00, 2'b11);
        check("thr_drained", 128'(empty), 128'(1));

        // Wrap-around steady state
        run(1, 2'b11, 2'b00);
        run(1, 2'b01, 2'b00);
        run(40, 2'b11, 2'b11);
        check("wrap_count", 128'(count), 128'(3));
        run(2, 2'b00, 2'b11);

        // Simultaneous enqueue/dequeue at full
        run(8, 2'b11, 2'b00);
        run(1, 2'b11, 2'b11);
        check("full_simul_count", 128'(count), 128'(14));
        run(1, 2'b11, 2'b00);
        check("full_refill_count", 128'(count), 128'(16));
        run(8, 2'b00, 2'b11);

        // Flush with enqueue and dequeue requested
        run(4, 2'b11, 2'b00);
        run(1, 2'b01, 2'b00);
        check("pre_flush_count", 128'(count), 128'(9));
        enq_valid = 2'b11;
        deq_ready = 2'b11;
        flush     = 1'b1;
        #1;
        check("flush_deq_valid", 128'(deq_valid), 128'(0));
        check("flush_enq_ready", 128'(enq_ready), 128'(0));
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("post_flush_count", 128'(count), 128'(0));
        check("post_flush_empty", 128'(empty), 128'(1));
        run(1, 2'b01, 2'b00);
        check("post_flush_pc", 128'(deq_data[63:32]), 128'(next_pc - 4));
        run(1, 2'b00, 2'b01);

        // Randomized traffic with occasional flush
        for (int k = 0; k < 300; k++)
            drive(WW'($urandom()), RW'($urandom()), $urandom_range(29) == 0);
        run(8, 2'b00, 2'b11);
        check("rand_drained", 128'(empty), 128'(1));

        // Asynchronous reset mid-stream at count 7
        run(3, 2'b11, 2'b00);
        run(1, 2'b01, 2'b00);
        check("pre_rst_count", 128'(count), 128'(7));
        enq_valid = '0;
        deq_ready = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_count", 128'(count), 128'(0));
        check("async_deq_valid", 128'(deq_valid), 128'(0));
        check("async_deq_data", 128'(deq_data[EW-1:0]), 128'(0));
        check("async_enq_ready", 128'(enq_ready), 128'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(1, 2'b01, 2'b00);
        check("after_rst_count", 128'(count), 128'(1));
        run(2, 2'b00, 2'b11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_queue_mw.md
# inst_queue_mw

Multi-wide instruction queue between fetch and decode/dispatch. It is the superscalar successor to the single-entry-per-cycle instruction FIFO. Each cycle it accepts up to WR_WIDTH fetched entries and presents up to RD_WIDTH oldest entries in program order. It supports partial dequeue, a same-cycle flush for branch mispredicts, and an occupancy count for fetch throttling.

## Interface
- ENTRY_WIDTH, 102: payload bits per entry (inst 32, pc 32, branch_pattern 4, saturating_counter 2, pc_target_predict 32); opaque to the block.
- DEPTH, 16: entry count; power of two, DEPTH >= 2*max(WR_WIDTH, RD_WIDTH).
- WR_WIDTH, 2: enqueue slots per cycle (1..4).
- RD_WIDTH, 2: dequeue slots per cycle (1..4).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all contents at next edge.
- enq_valid  in  WR_WIDTH  per-slot write request; slot 0 is the oldest.
- enq_data  in  WR_WIDTH*ENTRY_WIDTH  slot i at bits [i*ENTRY_WIDTH +: ENTRY_WIDTH].
- enq_ready  out  1  whole enqueue group will be accepted.
- deq_valid  out  RD_WIDTH  slot i holds the i-th oldest entry.
- deq_data  out  RD_WIDTH*ENTRY_WIDTH  same slot packing as enq_data.
- deq_ready  in  RD_WIDTH  consumer takes slot i this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- State:
  - wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits with a wrap bit.
  - count register.
  - Storage array; not reset.
- Physical slot index is (ptr + i) mod DEPTH. Pointers wrap naturally at 2*DEPTH.
- n_enq is the number of leading ones in enq_valid. Bits after the first zero are ignored.
- enq_ready = !flush && (DEPTH - count) >= WR_WIDTH.
  - The check is all-or-nothing against the full width, independent of n_enq.
  - It is combinational from registered state only; it never depends on same-cycle dequeues.
- On an edge with enq_ready and n_enq > 0:
  - Slots 0..n_enq-1 are written at wr_ptr+0..n_enq-1.
  - wr_ptr advances by n_enq.
- deq_valid[i] = !flush && (count > i). deq_data slot i = mem[rd_ptr+i] when deq_valid[i], else all zeros.
- n_deq is the number of leading ones in (deq_ready & deq_valid). rd_ptr advances by n_deq.
- count_next = count + (enq accepted ? n_enq : 0) - n_deq.
  - Simultaneous enqueue and dequeue are legal at any occupancy, including full and empty.
- No bypass: an entry written this cycle is first visible on deq_data the following cycle.
- flush has priority over everything:
  - wr_ptr, rd_ptr and count go to 0 at the next edge.
  - No entry is written or popped that cycle.
  - enq_ready and deq_valid are forced low combinationally.
- Asynchronous reset (rst_n low), effective immediately regardless of clk:
  - Pointers and count = 0.
  - deq_valid = 0, deq_data = 0, enq_ready = 1, full = 0, empty = 1.
  - Reset asserted mid-operation drops all contents. The first legal enqueue is on the first rising edge after rst_n deasserts.

## Timing
- Enqueue-to-dequeue latency: 1 cycle. Data written at edge k appears on deq_data after edge k.
- Dequeue is zero-latency. The consumer samples deq_data in the same cycle it asserts deq_ready.
- count, full, empty, enq_ready and deq_valid change only after a clock edge or reset (or combinationally with flush). None of them depends on enq_valid or deq_ready.
- Sustained throughput is min(WR_WIDTH, RD_WIDTH) entries per cycle, holding steady with count <= DEPTH-WR_WIDTH.

## Test plan
- **Reset, basic fill and drain:** reset, enqueue 2 entries per cycle for 8 cycles (pc 0x0,0x4,...,0x3C) with deq_ready=0.
  - Required: count=16, full=1, enq_ready=0.
  - Then deq_ready=2'b11: pcs emerge in order, 2 per cycle, ending with empty=1.
- **Threshold and partial dequeue:**
  - count=15: enq_ready=0 even with enq_valid=2'b01.
  - deq_ready=2'b01 at count=15: count goes to 14 and enq_ready rises next cycle.
  - deq_ready=2'b10: no pop, since only leading ones count.
- **Wrap-around:** run 40 cycles of enqueue 2 / dequeue 2 starting from count=3.
  - Required: strict pc ordering across the pointer wrap, and count constant at 3.
- **Simultaneous at full:** at count=16 assert deq_ready=2'b11 with enq_valid=2'b11.
  - Required: 2 popped, none written (enq_ready=0 that cycle), count=14. The next cycle enqueue is accepted and count=16.
- **Flush:** at count=9 assert flush with enq_valid=2'b11 and deq_ready=2'b11.
  - Required: deq_valid=0 and enq_ready=0 that cycle, then count=0, empty=1. The next enqueue reads back correctly at slot 0.
- **Async reset mid-stream:** drop rst_n between edges at count=7.
  - Required: count=0, deq_valid=0, deq_data=0 immediately. After release, a single enqueue gives count=1 after one edge.
